fifo_read_ctrl: RTL and testbench
=================================

FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

Interface
REQ-001 SHALL have parameter DW, default 5: data width in bits.
REQ-002 SHALL have parameter AW, default 3: address width; FIFO depth = 2^AW = 8.
REQ-003 SHALL have parameter AE_LVL, default 1: almost_empty threshold in entries.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port wr_ptr  input  AW+1  write pointer from the write side, binary, MSB is the wrap bit, same clk domain.
REQ-007 SHALL have port rd_req  input  1  read request, sampled on the rising clk edge.
REQ-008 SHALL have port mem_rdata  input  DW  storage read data at rd_addr, combinational.
REQ-009 SHALL have port rd_addr  output  AW  storage read address, equal to rd_ptr[AW-1:0].
REQ-010 SHALL have port rd_ptr  output  AW+1  read pointer, binary, MSB is the wrap bit.
REQ-011 SHALL have port dout  output  DW  registered read data.
REQ-012 SHALL have port dout_valid  output  1  high for one cycle when dout holds newly popped data.
REQ-013 SHALL have port empty  output  1  FIFO holds no entries.
REQ-014 SHALL have port almost_empty  output  1  occupancy <= AE_LVL.
REQ-015 SHALL have port count  output  AW+1  occupancy, 0..2^AW.
REQ-016 SHALL have port underflow  output  1  one-cycle pulse on a rejected read.

Function
REQ-017 SHALL compute count = (wr_ptr - rd_ptr) modulo 2^(AW+1), combinationally.
REQ-018 SHALL assert empty combinationally when wr_ptr == rd_ptr, including the wrap bit.
REQ-019 SHALL assert almost_empty combinationally when count <= AE_LVL.
REQ-020 SHALL accept a read when rd_req=1 and empty=0 at the clock edge.
REQ-021 On an accepted read: dout <= mem_rdata, rd_ptr <= rd_ptr+1 modulo 2^(AW+1), dout_valid <= 1; the pop has 1-cycle latency.
REQ-022 On a rejected read (rd_req=1, empty=1): rd_ptr and dout SHALL hold, dout_valid <= 0, underflow <= 1 for exactly one cycle.
REQ-023 When rd_req=0: rd_ptr and dout SHALL hold, dout_valid <= 0, underflow <= 0.
REQ-024 Pointer wrap: rd_ptr SHALL go from 2^(AW+1)-1 to 0, so the wrap bit toggles each time rd_addr wraps 7->0.
REQ-025 Back-to-back accepted reads SHALL sustain one pop per cycle, with dout_valid held high continuously.
REQ-026 Simultaneous write/read: empty and count SHALL follow the wr_ptr value present at the edge; a wr_ptr advancing in the same cycle as an empty-state rd_req SHALL NOT make that read accepted.
REQ-027 count = 2^AW (full, wrap bits differ, low bits equal) SHALL be reported as 8, not 0; empty SHALL be 0 in that case.
REQ-028 Neither dout nor rd_ptr SHALL ever change on a cycle without an accepted read.

Reset
REQ-029 While rst=1, asynchronously: rd_ptr=0, rd_addr=0, dout=0, dout_valid=0, underflow=0.
REQ-030 With rst=1 and wr_ptr=0: empty=1, almost_empty=1, count=0.
REQ-031 Reset asserted mid-burst SHALL abort the burst immediately, with no further pop; the write side is reset by the same rst.
REQ-032 The first accepted read SHALL occur at the first rising edge after rst deasserts with rd_req=1 and empty=0.

Verification
REQ-033 Reset, then rd_req=1 with wr_ptr=0 -> underflow pulses 1 cycle, rd_ptr stays 0, dout=0, dout_valid=0.
REQ-034 wr_ptr=3, mem_rdata driven as 5'h11/5'h12/5'h13 for addr 0/1/2, rd_req=1 for 3 cycles -> dout 11,12,13 on successive cycles, dout_valid high 3 cycles, then empty=1, count=0, rd_ptr=3.
REQ-035 rd_ptr=4'b0111, wr_ptr=4'b1001, pop twice -> rd_addr 7 then 0, rd_ptr=4'b1001, empty=1.
REQ-036 wr_ptr=4'b1000, rd_ptr=0 -> count=8, empty=0, almost_empty=0; after 7 pops -> count=1, almost_empty=1.
REQ-037 rst asserted between pop 2 and pop 3 of a 5-pop burst -> outputs zero asynchronously, no pop 3, and after release the first pop reads addr 0.

Source files
------------

// File: rtl/fifo_read_ctrl.sv
// rtl/fifo_read_ctrl.sv - FIFO read-side controller: read pointer, status flags, registered pop data
module fifo_read_ctrl #(
   parameter int DW     = 5,
   parameter int AW     = 3,
   parameter int AE_LVL = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW:0]   wr_ptr,
   input  logic          rd_req,
   input  logic [DW-1:0] mem_rdata,
   output logic [AW-1:0] rd_addr,
   output logic [AW:0]   rd_ptr,
   output logic [DW-1:0] dout,
   output logic          dout_valid,
   output logic          empty,
   output logic          almost_empty,
   output logic [AW:0]   count,
   output logic          underflow
);

   localparam logic [AW:0] AE_LVL_W = (AW+1)'(AE_LVL);

   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic [DW-1:0] dout_q, dout_d;
   logic          dout_valid_q, dout_valid_d;
   logic          underflow_q, underflow_d;
   logic          rd_accept;

   // Wrap bit makes full (count = 2^AW) distinguishable from empty.
   always_comb begin
      count        = wr_ptr - rd_ptr_q;
      empty        = (wr_ptr == rd_ptr_q);
      almost_empty = (count <= AE_LVL_W);
      rd_accept    = rd_req && !empty;
   end

   always_comb begin
      rd_ptr_d     = rd_ptr_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      underflow_d  = 1'b0;
      if (rd_accept) begin
         rd_ptr_d     = rd_ptr_q + 1'b1;
         dout_d       = mem_rdata;
         dout_valid_d = 1'b1;
      end else if (rd_req) begin
         underflow_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q     <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         rd_ptr_q     <= rd_ptr_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         underflow_q  <= underflow_d;
      end
   end

   assign rd_ptr     = rd_ptr_q;
   assign rd_addr    = rd_ptr_q[AW-1:0];
   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign underflow  = underflow_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb/tb_fifo_read_ctrl.sv - directed bench for fifo_read_ctrl
module tb_fifo_read_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] wr_ptr = '0;
   logic       rd_req = 1'b0;
   logic [4:0] mem_rdata;
   logic [2:0] rd_addr;
   logic [3:0] rd_ptr;
   logic [4:0] dout;
   logic       dout_valid;
   logic       empty;
   logic       almost_empty;
   logic [3:0] count;
   logic       underflow;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Storage model: entry at address a holds 5'h11 + a.
   assign mem_rdata = 5'h11 + {2'b00, rd_addr};

   fifo_read_ctrl #(.DW(5), .AW(3), .AE_LVL(1)) dut (
      .clk(clk), .rst(rst), .wr_ptr(wr_ptr), .rd_req(rd_req), .mem_rdata(mem_rdata),
      .rd_addr(rd_addr), .rd_ptr(rd_ptr), .dout(dout), .dout_valid(dout_valid),
      .empty(empty), .almost_empty(almost_empty), .count(count), .underflow(underflow)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      step();
      check("rst_rd_ptr", rd_ptr, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_dout", dout, 0);
      check("rst_dv", dout_valid, 0);
      check("rst_uf", underflow, 0);
      check("rst_empty", empty, 1);
      check("rst_ae", almost_empty, 1);
      check("rst_count", count, 0);

      // Underflow on empty read
      rst = 1'b0;
      rd_req = 1'b1;
      step();
      check("uf_pulse", underflow, 1);
      check("uf_rd_ptr", rd_ptr, 0);
      check("uf_dout", dout, 0);
      check("uf_dv", dout_valid, 0);
      rd_req = 1'b0;
      step();
      check("uf_clear", underflow, 0);

      // Three back-to-back pops
      wr_ptr = 4'd3;
      rd_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("b2b_dout", dout, 5'h11 + i);
         check("b2b_dv", dout_valid, 1);
         check("b2b_rd_ptr", rd_ptr, i + 1);
      end
      check("b2b_empty", empty, 1);
      check("b2b_count", count, 0);
      rd_req = 1'b0;
      step();
      check("idle_dv", dout_valid, 0);
      check("idle_dout_hold", dout, 5'h13);
      check("idle_ptr_hold", rd_ptr, 3);

      // Read on empty while write side advances at the same edge: rejected
      rd_req = 1'b1;
      step();
      wr_ptr = 4'd4;
      check("simul_uf", underflow, 1);
      check("simul_ptr", rd_ptr, 3);
      check("simul_dv", dout_valid, 0);
      check("simul_dout", dout, 5'h13);
      step();
      check("simul_next_dout", dout, 5'h14);
      check("simul_next_ptr", rd_ptr, 4);
      check("simul_next_uf", underflow, 0);
      rd_req = 1'b0;

      // Full FIFO, drain to one entry, then wrap
      rst = 1'b1;
      #2;
      check("arst_ptr", rd_ptr, 0);
      check("arst_dout", dout, 0);
      wr_ptr = 4'd0;
      step();
      rst = 1'b0;
      wr_ptr = 4'b1000;
      #1;
      check("full_count", count, 8);
      check("full_empty", empty, 0);
      check("full_ae", almost_empty, 0);
      rd_req = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
         check("drain_dout", dout, 5'h11 + i);
      end
      rd_req = 1'b0;
      #1;
      check("drain_count", count, 1);
      check("drain_ae", almost_empty, 1);
      check("drain_empty", empty, 0);
      check("drain_ptr", rd_ptr, 4'b0111);
      check("wrap_addr7", rd_addr, 7);
      wr_ptr = 4'b1001;
      rd_req = 1'b1;
      #1;
      check("wrap_count", count, 2);
      step();
      check("wrap_dout7", dout, 5'h18);
      check("wrap_addr0", rd_addr, 0);
      check("wrap_ptr8", rd_ptr, 4'b1000);
      step();
      check("wrap_dout0", dout, 5'h11);
      check("wrap_ptr9", rd_ptr, 4'b1001);
      check("wrap_empty", empty, 1);
      rd_req = 1'b0;

      // Reset mid-burst
      rst = 1'b1;
      wr_ptr = 4'd0;
      step();
      rst = 1'b0;
      wr_ptr = 4'd5;
      rd_req = 1'b1;
      step();
      check("burst_pop1", dout, 5'h11);
      step();
      check("burst_pop2", dout, 5'h12);
      check("burst_ptr2", rd_ptr, 2);
      rst = 1'b1;
      wr_ptr = 4'd0;
      #2;
      check("mid_rst_ptr", rd_ptr, 0);
      check("mid_rst_dout", dout, 0);
      check("mid_rst_dv", dout_valid, 0);
      check("mid_rst_uf", underflow, 0);
      step();
      check("mid_rst_nopop", dout, 0);
      check("mid_rst_dv2", dout_valid, 0);
      rst = 1'b0;
      wr_ptr = 4'd2;
      step();
      check("post_rst_dout", dout, 5'h11);
      check("post_rst_ptr", rd_ptr, 1);
      check("post_rst_dv", dout_valid, 1);
      rd_req = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
